// File: rtl/pwr_seq_ctrl.sv
// Power sequencer: staggers the LV and VP12 rail enables, then boots the XMC.
// Qualified rail alerts force a full shutdown and latch the fault source.
module pwr_seq_ctrl #(
  parameter int unsigned SETTLE_CYC  = 100000,
  parameter int unsigned STAGGER_CYC = 10000,
  parameter int unsigned XMC_RST_CYC = 50000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk_axi,
  input  logic       rst,
  input  logic       pwr_req,
  input  logic [5:0] vp12_mask,
  input  logic       fault_clr,
  input  logic       vp3v3_alert_n,
  input  logic       vp2v5_alert_n,
  input  logic [5:0] vp12_alert_n,
  output logic       en_3v3,
  output logic       en_2v5,
  output logic [5:0] vp12_en,
  output logic       xmc_jtag_en,
  output logic       xmc_reset_n,
  output logic [2:0] state,
  output logic       done,
  output logic       fault,
  output logic [7:0] fault_src
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_LV_ON = 3'd1,
    S_RAMP  = 3'd2,
    S_BOOT  = 3'd3,
    S_ON    = 3'd4,
    S_DOWN  = 3'd5,
    S_FAULT = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] STAG_LD   = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] XMC_LD    = CNT_W'(XMC_RST_CYC - 1);

  logic [7:0]      alert_n;
  logic [7:0]      sync1_q, sync2_q;
  logic [7:0][2:0] qcnt_q, qcnt_d;
  logic [7:0]      qual;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]      mask_q, mask_d;
  logic            lv_q, lv_d;
  logic [5:0]      vp_q, vp_d;
  logic            jtag_q, jtag_d;
  logic            rstn_q, rstn_d;
  logic            done_q, done_d;
  logic            fault_q, fault_d;
  logic [7:0]      src_q, src_d;

  logic            expired;
  logic [5:0]      pend, low_oh, hi_oh;
  logic            mon_lv, mon_vp, flt;

  // bit order matches fault_src: {vp12[5:0], 2V5, 3V3}
  assign alert_n = {vp12_alert_n, vp2v5_alert_n, vp3v3_alert_n};

  always_ff @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      qcnt_q  <= '0;
    end else begin
      sync1_q <= alert_n;
      sync2_q <= sync1_q;
      qcnt_q  <= qcnt_d;
    end
  end

  // qualified once four consecutive low samples have been seen
  always_comb begin
    qcnt_d = qcnt_q;
    qual   = '0;
    for (int i = 0; i < 8; i++) begin
      qual[i] = (qcnt_q[i] == 3'd4);
      if (sync2_q[i]) begin
        qcnt_d[i] = 3'd0;
      end else if (!qual[i]) begin
        qcnt_d[i] = qcnt_q[i] + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      mask_q  <= '0;
      lv_q    <= 1'b0;
      vp_q    <= '0;
      jtag_q  <= 1'b0;
      rstn_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      lv_q    <= lv_d;
      vp_q    <= vp_d;
      jtag_q  <= jtag_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    mask_d  = mask_q;
    lv_d    = lv_q;
    vp_d    = vp_q;
    jtag_d  = jtag_q;
    rstn_d  = rstn_q;
    done_d  = done_q;
    fault_d = fault_q;
    src_d   = src_q;

    expired = (cnt_q == '0);
    pend    = mask_q & ~vp_q;
    low_oh  = pend & (~pend + 6'd1);
    hi_oh   = '0;
    for (int i = 0; i < 6; i++) begin
      if (vp_q[i]) begin
        hi_oh    = '0;
        hi_oh[i] = 1'b1;
      end
    end

    mon_lv = (state_q == S_RAMP) || (state_q == S_BOOT) ||
             (state_q == S_ON);
    mon_vp = (state_q == S_BOOT) || (state_q == S_ON);
    flt    = (mon_lv && (qual[0] || qual[1])) ||
             (mon_vp && (|(qual[7:2] & vp_q)));

    if (flt) begin
      state_d = S_FAULT;
      lv_d    = 1'b0;
      vp_d    = '0;
      jtag_d  = 1'b0;
      rstn_d  = 1'b0;
      done_d  = 1'b0;
      fault_d = 1'b1;
      src_d   = qual;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (pwr_req && !fault_q) begin
            mask_d  = vp12_mask;
            lv_d    = 1'b1;
            cnt_d   = SETTLE_LD;
            state_d = S_LV_ON;
          end
        end
        S_LV_ON, S_RAMP: begin
          if (!pwr_req) begin
            state_d = S_DOWN;
            jtag_d  = 1'b0;
            rstn_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = STAG_LD;
          end else if (expired) begin
            if (|pend) begin
              vp_d    = vp_q | low_oh;
              cnt_d   = STAG_LD;
              state_d = S_RAMP;
            end else begin
              jtag_d  = 1'b1;
              cnt_d   = XMC_LD;
              state_d = S_BOOT;
            end
          end
        end
        S_BOOT, S_ON: begin
          if (!pwr_req) begin
            state_d = S_DOWN;
            jtag_d  = 1'b0;
            rstn_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = STAG_LD;
          end else if (state_q == S_BOOT && expired) begin
            rstn_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_ON;
          end
        end
        S_DOWN: begin
          if (expired) begin
            if (|vp_q) begin
              vp_d  = vp_q & ~hi_oh;
              cnt_d = STAG_LD;
            end else begin
              lv_d    = 1'b0;
              state_d = S_OFF;
            end
          end
        end
        S_FAULT: begin
          if (fault_clr && !pwr_req) begin
            fault_d = 1'b0;
            src_d   = '0;
            state_d = S_OFF;
          end
        end
        default: begin
          state_d = S_OFF;
          lv_d    = 1'b0;
          vp_d    = '0;
          jtag_d  = 1'b0;
          rstn_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign en_3v3      = lv_q;
  assign en_2v5      = lv_q;
  assign vp12_en     = vp_q;
  assign xmc_jtag_en = jtag_q;
  assign xmc_reset_n = rstn_q;
  assign state       = state_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign fault_src   = src_q;

endmodule
